// File: rtl/fifo_axi_pkg.sv
// Shared types and helpers for the FIFO-to-AXI write burst engine.
package fifo_axi_pkg;

    typedef enum logic [1:0] {
        IDLE,
        AW,
        W,
        B
    } wr_state_e;

    localparam logic [1:0] INCR = 2'b01;

    function automatic int unsigned burst_bytes(input int unsigned beats,
                                                input int unsigned data_width);
        return beats * (data_width / 8);
    endfunction

endpackage

// File: rtl/fifo_rd_skid.sv
// Two-entry skid buffer turning a latency-1 FIFO read port into valid/ready,
// never requesting more than one burst worth of words between clears.
module fifo_rd_skid #(
    parameter int DATA_WIDTH = 256,
    parameter int BURST_LEN  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  en,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    input  logic                  fifo_rd_empty,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data
);

    localparam int CNT_W = $clog2(BURST_LEN + 1);
    localparam logic [CNT_W-1:0] LEN_C = CNT_W'(BURST_LEN);

    logic [CNT_W-1:0]      req_cnt;
    logic                  inflight;
    logic [1:0]            occ;
    logic [DATA_WIDTH-1:0] ent0;
    logic [DATA_WIDTH-1:0] ent1;
    logic                  push;
    logic                  pop;

    // Occupancy plus the word still in flight must leave room for the answer.
    assign fifo_rd_en = en && !fifo_rd_empty && (req_cnt < LEN_C)
                        && ((occ + {1'b0, inflight}) < 2'd2);
    assign out_valid  = (occ != 2'd0);
    assign out_data   = ent0;
    assign push       = inflight;
    assign pop        = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            req_cnt  <= '0;
            inflight <= 1'b0;
            occ      <= 2'd0;
        end else begin
            inflight <= fifo_rd_en;
            if (clr)
                req_cnt <= '0;
            else if (fifo_rd_en)
                req_cnt <= req_cnt + 1'b1;
            case ({push, pop})
                2'b10:   occ <= occ + 2'd1;
                2'b01:   occ <= occ - 2'd1;
                default: occ <= occ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        case ({push, pop})
            2'b10: begin
                if (occ == 2'd0)
                    ent0 <= fifo_rd_data;
                else
                    ent1 <= fifo_rd_data;
            end
            2'b01: ent0 <= ent1;
            2'b11: begin
                if (occ == 2'd1) begin
                    ent0 <= fifo_rd_data;
                end else begin
                    ent0 <= ent1;
                    ent1 <= fifo_rd_data;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/fifo_axi_wr_burst.sv
// Drains the async input FIFO into linear AXI4 INCR write bursts of a frame buffer.
// Optional response-error counter enabled by FIFO_AXI_WR_BRESP_CHK_EN.
module fifo_axi_wr_burst
    import fifo_axi_pkg::*;
#(
    parameter int DATA_WIDTH  = 256,
    parameter int ADDR_WIDTH  = 28,
    parameter int LEVEL_WIDTH = 8,
    parameter int BURST_LEN   = 16,
    parameter int FRAME_BASE  = 0,
    parameter int FRAME_BEATS = 49152
) (
    input  logic                    rd_clk,
    input  logic                    rd_rst,
    input  logic                    frame_start,
    output logic                    fifo_rd_en,
    input  logic [DATA_WIDTH-1:0]   fifo_rd_data,
    input  logic                    fifo_rd_empty,
    input  logic [LEVEL_WIDTH-1:0]  fifo_rd_water_level,
    output logic [ADDR_WIDTH-1:0]   m_awaddr,
    output logic [7:0]              m_awlen,
    output logic                    m_awvalid,
    input  logic                    m_awready,
    output logic [DATA_WIDTH-1:0]   m_wdata,
    output logic [DATA_WIDTH/8-1:0] m_wstrb,
    output logic                    m_wlast,
    output logic                    m_wvalid,
    input  logic                    m_wready,
    input  logic                    m_bvalid,
    output logic                    m_bready,
    output logic                    busy,
    output logic                    frame_done
`ifdef FIFO_AXI_WR_BRESP_CHK_EN
    ,
    input  logic [1:0]              m_bresp,
    output logic [15:0]             bresp_err_cnt
`endif
);

    localparam int BCNT_W = $clog2(BURST_LEN + 1);
    localparam int FCNT_W = $clog2(FRAME_BEATS + 1);
    localparam logic [ADDR_WIDTH-1:0]  BASE_A  = ADDR_WIDTH'(FRAME_BASE);
    localparam logic [ADDR_WIDTH-1:0]  STEP_A  = ADDR_WIDTH'(burst_bytes(BURST_LEN, DATA_WIDTH));
    localparam logic [FCNT_W:0]        LEN_F   = (FCNT_W + 1)'(BURST_LEN);
    localparam logic [FCNT_W:0]        FRAME_F = (FCNT_W + 1)'(FRAME_BEATS);
    localparam logic [LEVEL_WIDTH:0]   LEN_L   = (LEVEL_WIDTH + 1)'(BURST_LEN);
    localparam logic [BCNT_W-1:0]      LAST_B  = BCNT_W'(BURST_LEN - 1);

    wr_state_e             state;
    wr_state_e             state_nxt;
    logic [ADDR_WIDTH-1:0] awaddr;
    logic [FCNT_W-1:0]     frame_cnt;
    logic [FCNT_W:0]       frame_cnt_nxt;
    logic [BCNT_W-1:0]     beat_cnt;
    logic                  start_pend;
    logic                  start_now;
    logic                  beat;
    logic                  b_acc;
    logic                  wrap;
    logic                  skid_en;
    logic                  skid_clr;
    logic                  skid_ready;
    logic                  skid_valid;
    logic [DATA_WIDTH-1:0] skid_data;

    assign start_now     = (state == IDLE) && (frame_start || start_pend);
    assign beat          = m_wvalid && m_wready;
    assign b_acc         = (state == B) && m_bvalid;
    assign frame_cnt_nxt = {1'b0, frame_cnt} + LEN_F;
    assign wrap          = (frame_cnt_nxt >= FRAME_F);

    assign m_awaddr   = awaddr;
    assign m_awlen    = 8'(BURST_LEN - 1);
    assign m_wdata    = skid_data;
    assign m_wstrb    = '1;
    assign m_wlast    = m_wvalid && (beat_cnt == LAST_B);
    assign frame_done = b_acc && wrap;

    // A frame restart seen in IDLE holds the FSM there for that one cycle.
    always_comb begin
        state_nxt  = state;
        m_awvalid  = 1'b0;
        m_wvalid   = 1'b0;
        m_bready   = 1'b0;
        busy       = (state != IDLE);
        skid_en    = 1'b0;
        skid_clr   = 1'b0;
        skid_ready = 1'b0;
        case (state)
            IDLE: begin
                skid_clr = 1'b1;
                if (!start_now && ({1'b0, fifo_rd_water_level} >= LEN_L))
                    state_nxt = AW;
            end
            AW: begin
                m_awvalid = 1'b1;
                skid_en   = 1'b1;
                if (m_awready)
                    state_nxt = W;
            end
            W: begin
                skid_en    = 1'b1;
                skid_ready = m_wready;
                m_wvalid   = skid_valid;
                if (beat && m_wlast)
                    state_nxt = B;
            end
            B: begin
                m_bready = 1'b1;
                if (m_bvalid)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge rd_clk) begin
        if (rd_rst) begin
            state      <= IDLE;
            awaddr     <= BASE_A;
            frame_cnt  <= '0;
            beat_cnt   <= '0;
            start_pend <= 1'b0;
        end else begin
            state <= state_nxt;
            if (start_now) begin
                awaddr     <= BASE_A;
                frame_cnt  <= '0;
                start_pend <= 1'b0;
            end else if (frame_start) begin
                start_pend <= 1'b1;
            end
            if (beat)
                beat_cnt <= m_wlast ? '0 : beat_cnt + 1'b1;
            if (b_acc) begin
                if (wrap) begin
                    awaddr    <= BASE_A;
                    frame_cnt <= '0;
                end else begin
                    awaddr    <= awaddr + STEP_A;
                    frame_cnt <= frame_cnt_nxt[FCNT_W-1:0];
                end
            end
        end
    end

`ifdef FIFO_AXI_WR_BRESP_CHK_EN
    always_ff @(posedge rd_clk) begin
        if (rd_rst)
            bresp_err_cnt <= '0;
        else if (b_acc && (m_bresp != 2'b00) && (bresp_err_cnt != 16'hFFFF))
            bresp_err_cnt <= bresp_err_cnt + 16'd1;
    end
`endif

    fifo_rd_skid #(
        .DATA_WIDTH (DATA_WIDTH),
        .BURST_LEN  (BURST_LEN)
    ) u_skid (
        .clk           (rd_clk),
        .rst           (rd_rst),
        .clr           (skid_clr),
        .en            (skid_en),
        .fifo_rd_en    (fifo_rd_en),
        .fifo_rd_data  (fifo_rd_data),
        .fifo_rd_empty (fifo_rd_empty),
        .out_valid     (skid_valid),
        .out_ready     (skid_ready),
        .out_data      (skid_data)
    );

endmodule

// File: tb/tb_fifo_axi_wr_burst.sv
// Scoreboard bench for fifo_axi_wr_burst: a FIFO model, random AXI slave and reference address model.
module tb_fifo_axi_wr_burst;

    localparam int DW = 256;
    localparam int AWD = 28;
    localparam int LW = 8;
    localparam int BL = 16;
    localparam int FB = 32;
    localparam int BASE = 0;
    localparam int BYTES = BL * DW / 8;

    logic            rd_clk = 1'b0;
    logic            rd_rst = 1'b1;
    logic            frame_start = 1'b0;
    logic            fifo_rd_en;
    logic [DW-1:0]   fifo_rd_data;
    logic            fifo_rd_empty;
    logic [LW-1:0]   fifo_rd_water_level;
    logic [AWD-1:0]  m_awaddr;
    logic [7:0]      m_awlen;
    logic            m_awvalid;
    logic            m_awready = 1'b1;
    logic [DW-1:0]   m_wdata;
    logic [DW/8-1:0] m_wstrb;
    logic            m_wlast;
    logic            m_wvalid;
    logic            m_wready = 1'b1;
    logic            m_bvalid = 1'b0;
    logic            m_bready;
    logic            busy;
    logic            frame_done;
`ifdef FIFO_AXI_WR_BRESP_CHK_EN
    logic [1:0]      m_bresp;
    logic [15:0]     bresp_err_cnt;
    logic [1:0]      bresp_val = 2'b00;
    assign m_bresp = bresp_val;
`endif

    int tests = 0;
    int fails = 0;

    logic [DW-1:0] fifo_mem [0:1023];
    int wp = 0;
    int rp = 0;
    logic [DW-1:0] exp_data [$];
    int exp_aw [$];
    int exp_wrap [$];
    int m_cnt = 0;
    bit rnd_mode = 1'b0;
    int bh_cnt = 0;
    int wl_cnt = 0;
    int bt_cnt = 0;

    always #5 rd_clk = ~rd_clk;

    fifo_axi_wr_burst #(
        .DATA_WIDTH  (DW),
        .ADDR_WIDTH  (AWD),
        .LEVEL_WIDTH (LW),
        .BURST_LEN   (BL),
        .FRAME_BASE  (BASE),
        .FRAME_BEATS (FB)
    ) dut (
        .rd_clk              (rd_clk),
        .rd_rst              (rd_rst),
        .frame_start         (frame_start),
        .fifo_rd_en          (fifo_rd_en),
        .fifo_rd_data        (fifo_rd_data),
        .fifo_rd_empty       (fifo_rd_empty),
        .fifo_rd_water_level (fifo_rd_water_level),
        .m_awaddr            (m_awaddr),
        .m_awlen             (m_awlen),
        .m_awvalid           (m_awvalid),
        .m_awready           (m_awready),
        .m_wdata             (m_wdata),
        .m_wstrb             (m_wstrb),
        .m_wlast             (m_wlast),
        .m_wvalid            (m_wvalid),
        .m_wready            (m_wready),
        .m_bvalid            (m_bvalid),
        .m_bready            (m_bready),
        .busy                (busy),
        .frame_done          (frame_done)
`ifdef FIFO_AXI_WR_BRESP_CHK_EN
        ,
        .m_bresp             (m_bresp),
        .bresp_err_cnt       (bresp_err_cnt)
`endif
    );

    task automatic checki(input string name, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, got, got, exp, exp);
        end
    endtask

    task automatic checkw(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    // FIFO model: occupancy from pointers, read data one cycle after rd_en.
    assign fifo_rd_empty = (wp == rp);
    assign fifo_rd_water_level = ((wp - rp) > 255) ? 8'd255 : 8'(wp - rp);

    always @(posedge rd_clk) begin
        if (rd_rst)
            rp <= wp;
        else if (fifo_rd_en && (rp != wp)) begin
            fifo_rd_data <= fifo_mem[rp];
            rp <= rp + 1;
        end
    end

    // AXI slave driver: random ready, B response some cycles after each wlast.
    initial begin
        int bh_seen = 0;
        forever begin
            @(posedge rd_clk);
            #1;
            m_awready = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
            m_wready  = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
            if (m_bvalid && (bh_cnt != bh_seen))
                m_bvalid = 1'b0;
            bh_seen = bh_cnt;
            if (!m_bvalid && (wl_cnt > bh_cnt) && ($urandom_range(0, 2) == 0))
                m_bvalid = 1'b1;
        end
    end

    // Monitor: pops the scoreboard on every handshake.
    initial begin
        bit stall_aw = 1'b0;
        bit stall_w = 1'b0;
        int aw_prev = 0;
        logic [DW-1:0] w_prev = '0;
        int reads = 0;
        int bi = 0;
        forever begin
            @(negedge rd_clk);
            if (rd_rst) begin
                stall_aw = 1'b0;
                stall_w = 1'b0;
                reads = 0;
                bi = 0;
            end else begin
                if (fifo_rd_en) begin
                    checki("rd_while_empty", int'(fifo_rd_empty), 0);
                    reads++;
                end
                if (stall_aw) begin
                    checki("awvalid_hold", int'(m_awvalid), 1);
                    checki("awaddr_hold", int'(m_awaddr), aw_prev);
                end
                if (stall_w) begin
                    checki("wvalid_hold", int'(m_wvalid), 1);
                    checkw("wdata_hold", m_wdata, w_prev);
                end
                if (m_awvalid && m_awready) begin
                    checki("aw_expected", int'(exp_aw.size() != 0), 1);
                    if (exp_aw.size() != 0)
                        checki("awaddr", int'(m_awaddr), exp_aw.pop_front());
                    checki("awlen", int'(m_awlen), BL - 1);
                end
                if (m_wvalid && m_wready) begin
                    checki("w_expected", int'(exp_data.size() != 0), 1);
                    if (exp_data.size() != 0)
                        checkw("wdata", m_wdata, exp_data.pop_front());
                    checki("wlast", int'(m_wlast), int'(bi == BL - 1));
                    checki("wstrb", int'(m_wstrb == {(DW/8){1'b1}}), 1);
                    bt_cnt++;
                    if (bi == BL - 1) begin
                        bi = 0;
                        wl_cnt++;
                    end else begin
                        bi++;
                    end
                end
                if (m_bvalid && m_bready) begin
                    checki("b_expected", int'(exp_wrap.size() != 0), 1);
                    if (exp_wrap.size() != 0)
                        checki("frame_done", int'(frame_done), exp_wrap.pop_front());
                    checki("reads_per_burst", reads, BL);
                    reads = 0;
                    bh_cnt++;
                end else if (frame_done) begin
                    checki("frame_done_spurious", int'(frame_done), 0);
                end
                stall_aw = m_awvalid && !m_awready;
                aw_prev = int'(m_awaddr);
                stall_w = m_wvalid && !m_wready;
                w_prev = m_wdata;
            end
        end
    end

    task automatic tick();
        @(posedge rd_clk);
        #1;
    endtask

    task automatic push_words(input int n);
        logic [DW-1:0] w;
        for (int i = 0; i < n; i++) begin
            for (int k = 0; k < DW / 32; k++)
                w[32*k +: 32] = $urandom();
            fifo_mem[wp] = w;
            exp_data.push_back(w);
            wp++;
        end
    endtask

    // Reference: burst address is FRAME_BASE plus beats already written in this frame.
    task automatic expect_burst();
        exp_aw.push_back(BASE + (m_cnt / BL) * BYTES);
        m_cnt += BL;
        if (m_cnt >= FB) begin
            exp_wrap.push_back(1);
            m_cnt = 0;
        end else begin
            exp_wrap.push_back(0);
        end
    endtask

    task automatic wait_bh(input int target);
        int n = 0;
        while (bh_cnt < target && n < 3000) begin
            tick();
            n++;
        end
        checki("burst_timeout", int'(bh_cnt >= target), 1);
    endtask

    task automatic wait_bt(input int target);
        int n = 0;
        while (bt_cnt < target && n < 3000) begin
            tick();
            n++;
        end
        checki("beat_timeout", int'(bt_cnt >= target), 1);
    endtask

    task automatic pulse_start();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic check_reset_outputs();
        checki("rst_awvalid", int'(m_awvalid), 0);
        checki("rst_wvalid", int'(m_wvalid), 0);
        checki("rst_wlast", int'(m_wlast), 0);
        checki("rst_rd_en", int'(fifo_rd_en), 0);
        checki("rst_bready", int'(m_bready), 0);
        checki("rst_busy", int'(busy), 0);
        checki("rst_frame_done", int'(frame_done), 0);
        checki("rst_awaddr", int'(m_awaddr), BASE);
`ifdef FIFO_AXI_WR_BRESP_CHK_EN
        checki("rst_bresp_cnt", int'(bresp_err_cnt), 0);
`endif
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, tests %0d failed %0d", tests, fails + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) tick();
        check_reset_outputs();
        rd_rst = 1'b0;
        tick();

        // One word short of a burst must not start one.
        push_words(15);
        repeat (20) tick();
        checki("level15_busy", int'(busy), 0);
        checki("level15_awvalid", int'(m_awvalid), 0);
        expect_burst();
        push_words(1);
        wait_bh(1);

        // Random backpressure, two bursts queued at once, frame wraps after the second.
        rnd_mode = 1'b1;
        expect_burst();
        expect_burst();
        push_words(32);
        wait_bh(3);

        // frame_start during W at 512, then during W at 0, then while idle.
        expect_burst();
        push_words(16);
        wait_bt(bt_cnt + 3);
        pulse_start();
        m_cnt = 0;
        wait_bh(4);
        expect_burst();
        push_words(16);
        wait_bt(bt_cnt + 3);
        pulse_start();
        m_cnt = 0;
        wait_bh(5);
        expect_burst();
        push_words(16);
        wait_bh(6);
        repeat (3) tick();
        checki("idle_busy", int'(busy), 0);
        pulse_start();
        m_cnt = 0;
        expect_burst();
        push_words(16);
        wait_bh(7);

        // Reset in the middle of a burst at 512.
        rnd_mode = 1'b0;
        repeat (3) tick();
        expect_burst();
        push_words(16);
        wait_bt(bt_cnt + 4);
        rd_rst = 1'b1;
        tick();
        check_reset_outputs();
        exp_data.delete();
        exp_aw.delete();
        exp_wrap.delete();
        m_cnt = 0;
        rd_rst = 1'b0;
        tick();
        expect_burst();
        push_words(16);
        wait_bh(8);

`ifdef FIFO_AXI_WR_BRESP_CHK_EN
        checki("bresp_cnt_zero", int'(bresp_err_cnt), 0);
        bresp_val = 2'b10;
        rnd_mode = 1'b1;
        expect_burst();
        expect_burst();
        push_words(32);
        wait_bh(10);
        checki("bresp_cnt_two", int'(bresp_err_cnt), 2);
        bresp_val = 2'b00;
        expect_burst();
        push_words(16);
        wait_bh(11);
        checki("bresp_cnt_hold", int'(bresp_err_cnt), 2);
`endif

        repeat (5) tick();
        checki("data_drained", exp_data.size(), 0);
        checki("aw_drained", exp_aw.size(), 0);
        checki("b_drained", exp_wrap.size(), 0);
        checki("fifo_drained", wp - rp, 0);
        checki("final_busy", int'(busy), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
